// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite mover: edge policies, the RGB
// triple and the per-axis motion state carried through the edge logic.
package sprite_pkg;

    localparam int EDGE_RESPAWN = 0;
    localparam int EDGE_BOUNCE  = 1;
    localparam int EDGE_WRAP    = 2;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    // One axis of motion: widened signed position plus its signed step.
    typedef struct packed {
        logic signed [17:0] pos;
        logic signed [7:0]  vel;
    } axis_t;

    // A palette word is packed {R,G,B} with red in the most significant byte.
    function automatic rgb_t pal_unpack(input logic [23:0] word);
        return rgb_t'(word);
    endfunction

endpackage

// File: rtl/sprite_motion.sv
// Frame-tick detection and the per-frame position/velocity update, including
// the configured edge policy (respawn, bounce or wrap).
module sprite_motion
    import sprite_pkg::*;
#(
    parameter int SIZE      = 128,
    parameter int START_X   = 276,
    parameter int START_Y   = 96,
    parameter int VEL_X     = -1,
    parameter int VEL_Y     = 1,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 1280,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 720,
    parameter int EDGE_MODE = EDGE_RESPAWN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_sync,
    input  logic        freeze,
    input  logic        restart,
    output logic [15:0] pos_x,
    output logic [15:0] pos_y
);

    localparam logic signed [17:0] X_LO     = 18'(X_MIN);
    localparam logic signed [17:0] X_HI     = 18'(X_MAX - SIZE);
    localparam logic signed [17:0] Y_LO     = 18'(Y_MIN);
    localparam logic signed [17:0] Y_HI     = 18'(Y_MAX - SIZE);
    localparam logic [15:0]        POS_X0   = 16'(START_X);
    localparam logic [15:0]        POS_Y0   = 16'(START_Y);
    localparam logic signed [7:0]  VEL_X0   = 8'(VEL_X);
    localparam logic signed [7:0]  VEL_Y0   = 8'(VEL_Y);

    logic               v_sync_cur;
    logic               v_sync_prev;
    logic               tick;
    logic signed [7:0]  vel_x;
    logic signed [7:0]  vel_y;
    logic signed [17:0] cur_x;
    logic signed [17:0] cur_y;
    logic               out_of_range;
    axis_t              step_x;
    axis_t              step_y;
    logic [15:0]        next_pos_x;
    logic [15:0]        next_pos_y;
    logic signed [7:0]  next_vel_x;
    logic signed [7:0]  next_vel_y;

    // Bounce and wrap act on the candidate position; respawn is handled
    // separately because it looks at the current position instead.
    function automatic axis_t step_axis(input logic signed [17:0] pos,
                                        input logic signed [7:0]  vel,
                                        input logic signed [17:0] lo,
                                        input logic signed [17:0] hi);
        axis_t              res;
        logic signed [17:0] cand;
        cand    = pos + 18'(vel);
        res.pos = cand;
        res.vel = vel;
        if (EDGE_MODE == EDGE_BOUNCE) begin
            if (cand < lo) begin
                res.pos = lo;
                res.vel = -vel;
            end else if (cand > hi) begin
                res.pos = hi;
                res.vel = -vel;
            end
        end else if (EDGE_MODE == EDGE_WRAP) begin
            if (cand < lo) begin
                res.pos = hi;
            end else if (cand > hi) begin
                res.pos = lo;
            end
        end
        return res;
    endfunction

    assign tick  = v_sync_cur && !v_sync_prev;
    assign cur_x = $signed({2'b00, pos_x});
    assign cur_y = $signed({2'b00, pos_y});

    assign out_of_range = (cur_x <= X_LO) || (cur_x > X_HI) ||
                          (cur_y < Y_LO)  || (cur_y > Y_HI);

    always_comb begin
        step_x     = step_axis(cur_x, vel_x, X_LO, X_HI);
        step_y     = step_axis(cur_y, vel_y, Y_LO, Y_HI);
        next_pos_x = 16'(step_x.pos);
        next_pos_y = 16'(step_y.pos);
        next_vel_x = step_x.vel;
        next_vel_y = step_y.vel;
        if (EDGE_MODE == EDGE_RESPAWN && out_of_range) begin
            next_pos_x = POS_X0;
            next_pos_y = POS_Y0;
        end
    end

    // Restart wins over freeze and applies on any cycle; motion only on a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_sync_cur  <= 1'b0;
            v_sync_prev <= 1'b0;
            pos_x       <= POS_X0;
            pos_y       <= POS_Y0;
            vel_x       <= VEL_X0;
            vel_y       <= VEL_Y0;
        end else begin
            v_sync_cur  <= v_sync;
            v_sync_prev <= v_sync_cur;
            if (restart) begin
                pos_x <= POS_X0;
                pos_y <= POS_Y0;
                vel_x <= VEL_X0;
                vel_y <= VEL_Y0;
            end else if (tick && !freeze) begin
                pos_x <= next_pos_x;
                pos_y <= next_pos_y;
                vel_x <= next_vel_x;
                vel_y <= next_vel_y;
            end
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// One moving, scaled, palette-indexed sprite: hit box, ROM addressing and a
// one-cycle registered colour/hit output on top of the motion engine.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int SPR_LOG2   = 5,
    parameter int SCALE_LOG2 = 2,
    parameter int PAL_BITS   = 2,
    parameter logic [24*(2**PAL_BITS)-1:0] PALETTE =
        {24'hffffff, 24'h3a6ea5, 24'h9ad2ff, 24'h000000},
    parameter int START_X    = 276,
    parameter int START_Y    = 96,
    parameter int VEL_X      = -1,
    parameter int VEL_Y      = 1,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 1280,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 720,
    parameter int EDGE_MODE  = EDGE_RESPAWN
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_v_sync,
    input  logic [15:0]           i_x,
    input  logic [15:0]           i_y,
    input  logic                  i_is_finished,
    input  logic                  i_is_dead,
    input  logic                  i_restart,
    output logic [2*SPR_LOG2-1:0] o_rom_addr,
    input  logic [PAL_BITS-1:0]   i_pix_idx,
    output logic [7:0]            o_red,
    output logic [7:0]            o_green,
    output logic [7:0]            o_blue,
    output logic                  o_sprite_hit,
    output logic [15:0]           o_pos_x,
    output logic [15:0]           o_pos_y
);

    localparam int SIZE = 1 << (SPR_LOG2 + SCALE_LOG2);

    logic [15:0]         pos_x;
    logic [15:0]         pos_y;
    logic                in_box;
    logic [15:0]         dx;
    logic [15:0]         dy;
    logic [SPR_LOG2-1:0] tex_x;
    logic [SPR_LOG2-1:0] tex_y;
    rgb_t                pal_rgb;
    rgb_t                rgb_q;
    logic                hit_q;

    sprite_motion #(
        .SIZE      (SIZE),
        .START_X   (START_X),
        .START_Y   (START_Y),
        .VEL_X     (VEL_X),
        .VEL_Y     (VEL_Y),
        .X_MIN     (X_MIN),
        .X_MAX     (X_MAX),
        .Y_MIN     (Y_MIN),
        .Y_MAX     (Y_MAX),
        .EDGE_MODE (EDGE_MODE)
    ) u_motion (
        .clk     (i_clk),
        .rst     (i_rst),
        .v_sync  (i_v_sync),
        .freeze  (i_is_finished | i_is_dead),
        .restart (i_restart),
        .pos_x   (pos_x),
        .pos_y   (pos_y)
    );

    // 17-bit compares so pos+SIZE near the top of the 16-bit range cannot wrap.
    assign in_box = ({1'b0, i_x} >= {1'b0, pos_x}) &&
                    ({1'b0, i_x} <  {1'b0, pos_x} + 17'(SIZE)) &&
                    ({1'b0, i_y} >= {1'b0, pos_y}) &&
                    ({1'b0, i_y} <  {1'b0, pos_y} + 17'(SIZE));

    assign dx         = i_x - pos_x;
    assign dy         = i_y - pos_y;
    assign tex_x      = SPR_LOG2'(dx >> SCALE_LOG2);
    assign tex_y      = SPR_LOG2'(dy >> SCALE_LOG2);
    assign o_rom_addr = {tex_y, tex_x};

    assign pal_rgb = pal_unpack(PALETTE[int'(i_pix_idx)*24 +: 24]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rgb_q <= '0;
            hit_q <= 1'b0;
        end else begin
            hit_q <= in_box && (i_pix_idx != '0);
            rgb_q <= in_box ? pal_rgb : '0;
        end
    end

    assign o_red        = rgb_q.red;
    assign o_green      = rgb_q.green;
    assign o_blue       = rgb_q.blue;
    assign o_sprite_hit = hit_q;
    assign o_pos_x      = pos_x;
    assign o_pos_y      = pos_y;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench: five sprite_mover instances with different start/edge
// settings share one v_sync, with hand-computed positions and pixel outputs.
module tb_sprite_mover;

    localparam int A = 0;
    localparam int B = 1;
    localparam int C = 2;
    localparam int D = 3;
    localparam int E = 4;

    logic        clk;
    logic        rst;
    logic        v_sync;
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  pix_idx;
    logic [1:0]  pix_zero;
    logic [4:0]  restart;
    logic [4:0]  dead;
    logic [4:0]  finished;

    logic [9:0]  addr     [5];
    logic [7:0]  red      [5];
    logic [7:0]  green    [5];
    logic [7:0]  blue     [5];
    logic        hit      [5];
    logic [15:0] px       [5];
    logic [15:0] py       [5];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sprite_mover #(
        .PALETTE ({24'hffffff, 24'h3a6ea5, 24'h9ad2ff, 24'h102030})
    ) u_def (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_x(x), .i_y(y),
        .i_is_finished(finished[A]), .i_is_dead(dead[A]), .i_restart(restart[A]),
        .o_rom_addr(addr[A]), .i_pix_idx(pix_idx),
        .o_red(red[A]), .o_green(green[A]), .o_blue(blue[A]),
        .o_sprite_hit(hit[A]), .o_pos_x(px[A]), .o_pos_y(py[A])
    );

    sprite_mover #(
        .START_X (1)
    ) u_resp (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_x(x), .i_y(y),
        .i_is_finished(finished[B]), .i_is_dead(dead[B]), .i_restart(restart[B]),
        .o_rom_addr(addr[B]), .i_pix_idx(pix_zero),
        .o_red(red[B]), .o_green(green[B]), .o_blue(blue[B]),
        .o_sprite_hit(hit[B]), .o_pos_x(px[B]), .o_pos_y(py[B])
    );

    sprite_mover #(
        .START_X   (1151),
        .VEL_X     (3),
        .EDGE_MODE (1)
    ) u_bounce_hi (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_x(x), .i_y(y),
        .i_is_finished(finished[C]), .i_is_dead(dead[C]), .i_restart(restart[C]),
        .o_rom_addr(addr[C]), .i_pix_idx(pix_zero),
        .o_red(red[C]), .o_green(green[C]), .o_blue(blue[C]),
        .o_sprite_hit(hit[C]), .o_pos_x(px[C]), .o_pos_y(py[C])
    );

    sprite_mover #(
        .START_X   (1),
        .VEL_X     (-3),
        .EDGE_MODE (1)
    ) u_bounce_lo (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_x(x), .i_y(y),
        .i_is_finished(finished[D]), .i_is_dead(dead[D]), .i_restart(restart[D]),
        .o_rom_addr(addr[D]), .i_pix_idx(pix_zero),
        .o_red(red[D]), .o_green(green[D]), .o_blue(blue[D]),
        .o_sprite_hit(hit[D]), .o_pos_x(px[D]), .o_pos_y(py[D])
    );

    sprite_mover #(
        .START_Y   (590),
        .VEL_Y     (5),
        .EDGE_MODE (2)
    ) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_x(x), .i_y(y),
        .i_is_finished(finished[E]), .i_is_dead(dead[E]), .i_restart(restart[E]),
        .o_rom_addr(addr[E]), .i_pix_idx(pix_zero),
        .o_red(red[E]), .o_green(green[E]), .o_blue(blue[E]),
        .o_sprite_hit(hit[E]), .o_pos_x(px[E]), .o_pos_y(py[E])
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_pos(input string tag, input int idx,
                             input logic [15:0] ex, input logic [15:0] ey);
        check({tag, "_x"}, {16'h0, px[idx]}, {16'h0, ex});
        check({tag, "_y"}, {16'h0, py[idx]}, {16'h0, ey});
    endtask

    task automatic check_pixel(input string tag, input logic [23:0] ergb,
                               input logic ehit);
        check({tag, "_rgb"}, {8'h0, red[A], green[A], blue[A]}, {8'h0, ergb});
        check({tag, "_hit"}, {31'h0, hit[A]}, {31'h0, ehit});
    endtask

    // One v_sync pulse; the restart mask is asserted only on the tick cycle.
    task automatic frame_tick(input logic [4:0] tick_restart);
        v_sync = 1'b1;
        @(negedge clk);
        v_sync  = 1'b0;
        restart = tick_restart;
        @(negedge clk);
        restart = '0;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        v_sync   = 1'b0;
        x        = '0;
        y        = '0;
        pix_idx  = '0;
        pix_zero = '0;
        restart  = '0;
        dead     = '0;
        finished = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_pos("rst_a", A, 16'd276, 16'd96);
        check_pos("rst_b", B, 16'd1, 16'd96);
        check_pos("rst_c", C, 16'd1151, 16'd96);
        check_pos("rst_d", D, 16'd1, 16'd96);
        check_pos("rst_e", E, 16'd276, 16'd590);
        check_pixel("rst_pix", 24'h000000, 1'b0);

        // Pixel path against A at (276,96)
        x = 16'd319; y = 16'd128; pix_idx = 2'd1;
        #1 check("rom_addr", {22'h0, addr[A]}, {22'h0, 10'd266});
        @(negedge clk);
        check_pixel("pix_idx1", 24'h9ad2ff, 1'b1);
        pix_idx = 2'd0;
        @(negedge clk);
        check_pixel("pix_idx0", 24'h102030, 1'b0);
        x = 16'd275; pix_idx = 2'd1;
        @(negedge clk);
        check_pixel("pix_left", 24'h000000, 1'b0);
        x = 16'd403; y = 16'd96;
        #1 check("rom_addr_edge", {22'h0, addr[A]}, {22'h0, 10'd31});
        @(negedge clk);
        check_pixel("pix_right_in", 24'h9ad2ff, 1'b1);
        x = 16'd404;
        @(negedge clk);
        check_pixel("pix_right_out", 24'h000000, 1'b0);
        x = '0; y = '0; pix_idx = '0;
        @(negedge clk);

        // Tick 1, with a check that nothing moves before the tick cycle ends
        v_sync = 1'b1;
        @(negedge clk);
        check_pos("t1_hold_a", A, 16'd276, 16'd96);
        v_sync = 1'b0;
        @(negedge clk);
        check_pos("t1_a", A, 16'd275, 16'd97);
        check_pos("t1_b", B, 16'd0, 16'd97);
        check_pos("t1_c", C, 16'd1152, 16'd97);
        check_pos("t1_d", D, 16'd0, 16'd97);
        check_pos("t1_e", E, 16'd275, 16'd0);
        @(negedge clk);

        frame_tick(5'b00000);
        check_pos("t2_a", A, 16'd274, 16'd98);
        check_pos("t2_b", B, 16'd1, 16'd96);
        check_pos("t2_c", C, 16'd1149, 16'd98);
        check_pos("t2_d", D, 16'd3, 16'd98);
        check_pos("t2_e", E, 16'd274, 16'd5);

        dead[E]     = 1'b1;
        finished[D] = 1'b1;
        frame_tick(5'b00100);
        check_pos("t3_a", A, 16'd273, 16'd99);
        check_pos("t3_b", B, 16'd0, 16'd97);
        check_pos("t3_c_restart", C, 16'd1151, 16'd96);
        check_pos("t3_d_finished", D, 16'd3, 16'd98);
        check_pos("t3_e_dead", E, 16'd274, 16'd5);

        finished[D] = 1'b0;
        frame_tick(5'b00000);
        check_pos("t4_a", A, 16'd272, 16'd100);
        check_pos("t4_b", B, 16'd1, 16'd96);
        check_pos("t4_c_vel", C, 16'd1152, 16'd97);
        check_pos("t4_d", D, 16'd6, 16'd99);
        check_pos("t4_e_dead", E, 16'd274, 16'd5);

        frame_tick(5'b00000);
        check_pos("t5_c", C, 16'd1149, 16'd98);
        frame_tick(5'b00000);
        check_pos("t6_a", A, 16'd270, 16'd102);
        check_pos("t6_e_dead", E, 16'd274, 16'd5);

        // Restart during freeze on a non-tick cycle
        restart[E] = 1'b1;
        @(negedge clk);
        restart[E] = 1'b0;
        check_pos("e_restart", E, 16'd276, 16'd590);
        frame_tick(5'b00000);
        check_pos("t7_e_dead", E, 16'd276, 16'd590);
        dead[E] = 1'b0;
        frame_tick(5'b00000);
        check_pos("t8_e_wrap", E, 16'd275, 16'd0);

        // Mid-frame reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_pos("rst2_a", A, 16'd276, 16'd96);
        check_pos("rst2_c", C, 16'd1151, 16'd96);
        frame_tick(5'b00000);
        check_pos("rst2_t1_a", A, 16'd275, 16'd97);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
